// File: rtl/typer_pkg.sv
// -----------------------------------------------------------------------------
// typer_pkg
// Shared definitions for the text typer front end: default text-area geometry,
// the character codes the feeder interprets, and the feeder FSM state type.
// -----------------------------------------------------------------------------
package typer_pkg;

    // Default text-area geometry: 640 px / 20 px columns, 210 px / 30 px rows.
    localparam int unsigned COLS = 32;
    localparam int unsigned ROWS = 7;

    localparam logic [7:0] CH_NL        = 8'h0A;
    localparam logic [7:0] CH_BS        = 8'h08;
    localparam logic [7:0] CH_SPACE     = 8'h20;
    localparam logic [7:0] CH_PRINT_MAX = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } feeder_state_e;

    // True for codes that produce a visible glyph cell.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_SPACE) && (c <= CH_PRINT_MAX);
    endfunction

endpackage

// File: rtl/typer_char_fifo.sv
// -----------------------------------------------------------------------------
// typer_char_fifo
// Synchronous DEPTH x 8 character FIFO with a combinational head output.
//
// Ports:
//   clk_i    : clock, all state on posedge
//   rst_ni   : asynchronous active-low reset, flushes the FIFO
//   push_i   : write din_i this cycle (ignored while full)
//   din_i    : byte to write
//   pop_i    : drop the head this cycle (ignored while empty)
//   dout_o   : current head byte (valid when !empty_o)
//   count_o  : occupancy, 0..DEPTH
//   full_o   : count_o == DEPTH
//   empty_o  : count_o == 0
// -----------------------------------------------------------------------------
module typer_char_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [7:0]               din_i,
    input  logic                     pop_i,
    output logic [7:0]               dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Full is taken from the registered count, so a push while full is refused
    // even when a pop happens in the same cycle.
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/typer_feeder.sv
// -----------------------------------------------------------------------------
// typer_feeder
// Upstream stage of the on-screen text typer. Buffers ASCII bytes in a FIFO,
// tracks the text cursor, and issues one glyph at a time to the typer using
// its start/finished handshake. Newlines and line/screen wrap are handled here.
//
// Optional feature macro: TYPER_BACKSPACE_EN
//   defined   : 0x08 moves the cursor back one cell and erases it with a space
//   undefined : 0x08 is discarded like any other control code
//
// Ports:
//   clock                   : system clock, posedge
//   resetn                  : asynchronous active-low reset
//   char_in / char_valid    : producer byte and its valid
//   char_ready              : FIFO can accept (fifo_count < DEPTH)
//   row_num / col_num       : cursor position of the issued glyph
//   character_input         : glyph code to the typer
//   start_writing_character : request to the typer
//   finished_saving_char    : typer idle (1) / busy (0)
//   fifo_count              : FIFO occupancy
//   feeder_busy             : FSM not in IDLE
// -----------------------------------------------------------------------------
module typer_feeder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned COLS  = typer_pkg::COLS,
    parameter int unsigned ROWS  = typer_pkg::ROWS
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [7:0]             char_in,
    input  logic                   char_valid,
    output logic                   char_ready,
    output logic [7:0]             row_num,
    output logic [7:0]             col_num,
    output logic [7:0]             character_input,
    output logic                   start_writing_character,
    input  logic                   finished_saving_char,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   feeder_busy
);

    import typer_pkg::*;

    localparam logic [7:0] COL_LAST = 8'(COLS - 1);
    localparam logic [7:0] ROW_LAST = 8'(ROWS - 1);

    feeder_state_e state_q, state_d;

    // Live cursor (next free cell) and the latched position of the glyph in flight.
    logic [7:0] row_q, row_d;
    logic [7:0] col_q, col_d;
    logic [7:0] out_row_q, out_row_d;
    logic [7:0] out_col_q, out_col_d;
    logic [7:0] char_q, char_d;
    logic       start_q, start_d;
    logic       erase_q, erase_d;

    logic       fifo_pop;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    typer_char_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (resetn),
        .push_i  (char_valid),
        .din_i   (char_in),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign char_ready              = !fifo_full;
    assign row_num                 = out_row_q;
    assign col_num                 = out_col_q;
    assign character_input         = char_q;
    assign start_writing_character = start_q;
    assign feeder_busy             = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        char_d    = char_q;
        start_d   = 1'b0;
        erase_d   = erase_q;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                // Waiting for finished high also covers a reset taken while the
                // typer was still drawing: nothing is issued until it is idle.
                if (!fifo_empty && finished_saving_char) begin
                    fifo_pop = 1'b1;
                    if (fifo_head == CH_NL) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 8'd1;
                    end else if (is_printable(fifo_head)) begin
                        char_d    = fifo_head;
                        out_row_d = row_q;
                        out_col_d = col_q;
                        erase_d   = 1'b0;
                        state_d   = ISSUE;
                    end
`ifdef TYPER_BACKSPACE_EN
                    else if (fifo_head == CH_BS && (row_q != '0 || col_q != '0)) begin
                        // Step back first, then blank the cell we landed on; the
                        // cursor stays there because WAIT_DONE skips the advance.
                        if (col_q != '0) begin
                            col_d = col_q - 8'd1;
                        end else begin
                            row_d = row_q - 8'd1;
                            col_d = COL_LAST;
                        end
                        char_d    = CH_SPACE;
                        out_row_d = row_d;
                        out_col_d = col_d;
                        erase_d   = 1'b1;
                        state_d   = ISSUE;
                    end
`endif
                end
            end

            ISSUE: begin
                start_d = 1'b1;
                state_d = WAIT_ACK;
            end

            WAIT_ACK: begin
                if (!finished_saving_char) begin
                    state_d = WAIT_DONE;
                end else begin
                    start_d = 1'b1;
                end
            end

            WAIT_DONE: begin
                if (finished_saving_char) begin
                    if (!erase_q) begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = (row_q == ROW_LAST) ? '0 : row_q + 8'd1;
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                    end
                    erase_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
            char_q    <= '0;
            start_q   <= 1'b0;
            erase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            char_q    <= char_d;
            start_q   <= start_d;
            erase_q   <= erase_d;
        end
    end

endmodule

// File: tb/tb_typer_feeder.sv
// -----------------------------------------------------------------------------
// tb_typer_feeder
// Self-checking bench for typer_feeder with a behavioural typer model that
// logs every {row, col, glyph} it accepts.
// -----------------------------------------------------------------------------
module tb_typer_feeder;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] row_num;
    logic [7:0] col_num;
    logic [7:0] character_input;
    logic       start_writing_character;
    logic       finished_saving_char;
    logic [4:0] fifo_count;
    logic       feeder_busy;

    always #5 clock = ~clock;

    typer_feeder #(
        .DEPTH (16),
        .COLS  (32),
        .ROWS  (7)
    ) dut (
        .clock                   (clock),
        .resetn                  (resetn),
        .char_in                 (char_in),
        .char_valid              (char_valid),
        .char_ready              (char_ready),
        .row_num                 (row_num),
        .col_num                 (col_num),
        .character_input         (character_input),
        .start_writing_character (start_writing_character),
        .finished_saving_char    (finished_saving_char),
        .fifo_count              (fifo_count),
        .feeder_busy             (feeder_busy)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [23:0] rec(input logic [7:0] r, input logic [7:0] c, input logic [7:0] ch);
        return {r, c, ch};
    endfunction

    // Typer model: accepts a start on the falling edge, stays busy busy_len
    // cycles, then reports idle again. hold_low forces it to look busy.
    logic [23:0] issued[$];
    int busy_len  = 4;
    int busy_left = 0;
    bit hold_low  = 1'b0;

    initial finished_saving_char = 1'b1;

    always @(negedge clock) begin
        if (hold_low) begin
            finished_saving_char = 1'b0;
            busy_left = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) finished_saving_char = 1'b1;
        end else if (finished_saving_char && start_writing_character) begin
            finished_saving_char = 1'b0;
            busy_left = busy_len;
            issued.push_back(rec(row_num, col_num, character_input));
        end else begin
            finished_saving_char = 1'b1;
        end
    end

    task automatic push(input logic [7:0] c);
        int n = 0;
        @(negedge clock);
        while (!char_ready && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (!char_ready) check("push_ready_timeout", 32'(char_ready), 32'd1);
        char_in    = c;
        char_valid = 1'b1;
        @(negedge clock);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(fifo_count == 5'd0 && !feeder_busy) && n < 20000);
        check({tag, "_drained"}, 32'(n < 20000), 32'd1);
    endtask

    typedef struct {
        logic [7:0] ch;
        logic       issue;
        logic [7:0] row;
        logic [7:0] col;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int base;
        int bad;
        int n;
        int starts;

        // Cursor enters the table at (0,2), left there by the "AB" sequence.
        tbl[0] = '{8'h61, 1'b1, 8'd0, 8'd2};  // 'a'
        tbl[1] = '{8'h0A, 1'b0, 8'd0, 8'd0};  // newline -> (1,0)
        tbl[2] = '{8'h07, 1'b0, 8'd0, 8'd0};  // BEL discarded
        tbl[3] = '{8'h7F, 1'b0, 8'd0, 8'd0};  // DEL, just above printable range
        tbl[4] = '{8'h7E, 1'b1, 8'd1, 8'd0};  // '~', top of printable range
        tbl[5] = '{8'h20, 1'b1, 8'd1, 8'd1};  // space, bottom of printable range
        tbl[6] = '{8'h1F, 1'b0, 8'd0, 8'd0};  // just below printable range
        tbl[7] = '{8'h0A, 1'b0, 8'd0, 8'd0};  // newline -> (2,0)
        tbl[8] = '{8'h30, 1'b1, 8'd2, 8'd0};  // '0'

        char_in    = 8'h00;
        char_valid = 1'b0;
        resetn     = 1'b0;
        @(negedge clock);
        check("rst_count",   32'(fifo_count), 32'd0);
        check("rst_ready",   32'(char_ready), 32'd1);
        check("rst_row",     32'(row_num), 32'd0);
        check("rst_col",     32'(col_num), 32'd0);
        check("rst_char",    32'(character_input), 32'd0);
        check("rst_start",   32'(start_writing_character), 32'd0);
        check("rst_busy",    32'(feeder_busy), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // "AB" with a slow typer, including first-character latency.
        busy_len = 600;
        char_in = 8'h41; char_valid = 1'b1;
        @(negedge clock);                     // edge N: push
        char_valid = 1'b0;
        check("lat_count_after_push", 32'(fifo_count), 32'd1);
        check("lat_idle_after_push",  32'(feeder_busy), 32'd0);
        @(negedge clock);                     // edge N+1: pop
        check("lat_pop_busy",  32'(feeder_busy), 32'd1);
        check("lat_pop_start", 32'(start_writing_character), 32'd0);
        check("lat_pop_count", 32'(fifo_count), 32'd0);
        char_in = 8'h42; char_valid = 1'b1;
        @(negedge clock);                     // edge N+2: start
        char_valid = 1'b0;
        check("lat_start_high", 32'(start_writing_character), 32'd1);
        check("lat_a_pos", 32'({row_num, col_num, character_input}), 32'(rec(8'd0, 8'd0, 8'h41)));
        repeat (100) @(negedge clock);
        check("b_waits_in_fifo", 32'(fifo_count), 32'd1);
        check("a_held_stable", 32'({row_num, col_num, character_input}), 32'(rec(8'd0, 8'd0, 8'h41)));
        check("a_start_dropped", 32'(start_writing_character), 32'd0);
        wait_idle("ab");
        check("ab_issue_count", 32'(issued.size()), 32'd2);
        check("ab_first",  32'(issued[0]), 32'(rec(8'd0, 8'd0, 8'h41)));
        check("ab_second", 32'(issued[1]), 32'(rec(8'd0, 8'd1, 8'h42)));

        // Table-driven single bytes.
        busy_len = 4;
        for (int i = 0; i < 9; i++) begin
            base = issued.size();
            push(tbl[i].ch);
            wait_idle($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_issues", i), 32'(issued.size() - base), 32'(tbl[i].issue));
            if (tbl[i].issue)
                check($sformatf("tbl%0d_rec", i), 32'(issued[base]),
                      32'(rec(tbl[i].row, tbl[i].col, tbl[i].ch)));
        end

        // 33 x 'X' from (0,0): wrap to the next row, then newline and 'Y'.
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        base = issued.size();
        for (int i = 0; i < 33; i++) push(8'h58);
        push(8'h0A);
        push(8'h59);
        wait_idle("xrun");
        check("xrun_issue_count", 32'(issued.size() - base), 32'd34);
        bad = 0;
        for (int k = 0; k < 33; k++)
            if (issued[base + k] !== rec(8'(k / 32), 8'(k % 32), 8'h58)) bad++;
        check("xrun_positions", 32'(bad), 32'd0);
        check("xrun_33rd", 32'(issued[base + 32]), 32'(rec(8'd1, 8'd0, 8'h58)));
        check("xrun_y",    32'(issued[base + 33]), 32'(rec(8'd2, 8'd0, 8'h59)));

        // Screen wrap: cursor to (6,31) from (2,1), then 'Z' and 'Q'.
        for (int i = 0; i < 4; i++) push(8'h0A);
        for (int i = 0; i < 31; i++) push(8'h2E);
        wait_idle("to_corner");
        base = issued.size();
        push(8'h5A);
        push(8'h51);
        wait_idle("corner");
        check("corner_issue_count", 32'(issued.size() - base), 32'd2);
        check("corner_z", 32'(issued[base]),     32'(rec(8'd6, 8'd31, 8'h5A)));
        check("corner_q", 32'(issued[base + 1]), 32'(rec(8'd0, 8'd0, 8'h51)));

        // Stalled typer: fill the FIFO, refuse the 17th byte, then drain in order.
        hold_low = 1'b1;
        repeat (2) @(negedge clock);
        base = issued.size();
        for (int i = 0; i < 16; i++) push(8'(8'h61 + i));
        check("full_count", 32'(fifo_count), 32'd16);
        check("full_ready", 32'(char_ready), 32'd0);
        check("full_no_pop", 32'(feeder_busy), 32'd0);
        char_in = 8'h71; char_valid = 1'b1;
        @(negedge clock);
        char_valid = 1'b0;
        check("full_refused_count", 32'(fifo_count), 32'd16);
        hold_low = 1'b0;
        wait_idle("drain");
        check("drain_issue_count", 32'(issued.size() - base), 32'd16);
        bad = 0;
        for (int k = 0; k < 16; k++)
            if (issued[base + k] !== rec(8'd0, 8'(1 + k), 8'(8'h61 + k))) bad++;
        check("drain_order", 32'(bad), 32'd0);

        // Reset in WAIT_DONE while the typer is still drawing.
        busy_len = 50;
        push(8'h52);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!(feeder_busy && !start_writing_character && !finished_saving_char) && n < 200);
        check("reach_wait_done", 32'(n < 200), 32'd1);
        hold_low = 1'b1;
        resetn   = 1'b0;
        #1;
        check("midrst_start", 32'(start_writing_character), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_pos",   32'({row_num, col_num}), 32'd0);
        check("midrst_busy",  32'(feeder_busy), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        base = issued.size();
        push(8'h53);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (start_writing_character) starts++;
        end
        check("midrst_no_start", 32'(starts), 32'd0);
        check("midrst_held", 32'(fifo_count), 32'd1);
        hold_low = 1'b0;
        busy_len = 4;
        wait_idle("midrst");
        check("midrst_issue_count", 32'(issued.size() - base), 32'd1);
        check("midrst_s", 32'(issued[base]), 32'(rec(8'd0, 8'd0, 8'h53)));

        // Backspace from (1,0).
        push(8'h0A);
        wait_idle("bs_nl");
        base = issued.size();
        push(8'h08);
        push(8'h4B);
        wait_idle("bs");
`ifdef TYPER_BACKSPACE_EN
        check("bs_issue_count", 32'(issued.size() - base), 32'd2);
        check("bs_erase", 32'(issued[base]),     32'(rec(8'd0, 8'd31, 8'h20)));
        check("bs_k",     32'(issued[base + 1]), 32'(rec(8'd0, 8'd31, 8'h4B)));
`else
        check("bs_issue_count", 32'(issued.size() - base), 32'd1);
        check("bs_k", 32'(issued[base]), 32'(rec(8'd1, 8'd0, 8'h4B)));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
